// File: rtl/aes_pkg.sv
// aes_pkg: shared AES MixColumns types, column count and the GF(2^8) xtime helper.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} mixcol_state_t;

    localparam int NUM_COLS = 4;

    function automatic logic [7:0] xt(input logic [7:0] xtime);
        return {xtime[6:0], 1'b0} ^ (xtime[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/mix_column.sv
// mix_column: combinational forward AES MixColumns multiplier for one 32-bit column (s0 in MSB).
module mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] s0, s1, s2, s3;

    always_comb begin
        {s0, s1, s2, s3} = col_i;
        col_o[31:24] = xt(s0) ^ xt(s1) ^ s1 ^ s2 ^ s3;
        col_o[23:16] = s0 ^ xt(s1) ^ xt(s2) ^ s2 ^ s3;
        col_o[15:8]  = s0 ^ s1 ^ xt(s2) ^ xt(s3) ^ s3;
        col_o[7:0]   = xt(s0) ^ s0 ^ s1 ^ s2 ^ xt(s3);
    end

endmodule

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential AES MixColumns, one column per clock through a shared multiplier.
// Optional MIXCOL_BYPASS_EN adds a Last input that passes columns through unmixed.
module mix_columns_seq
    import aes_pkg::*;
(
    input  logic         Clk,
    input  logic         Rst,
    input  logic         InValid,
    output logic         InReady,
    input  logic [127:0] DataIn,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [127:0] DataOut,
    output logic         Busy
`ifdef MIXCOL_BYPASS_EN
    ,
    input  logic         Last
`endif
);

    localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);

    mixcol_state_t state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [127:0]  st_q, st_d;
    logic [127:0]  dout_q, dout_d;
    logic [31:0]   col, mixed, res;
    logic          accept;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE && InValid)         ? CALC :
                  (state_q == CALC && cnt_q == LAST_COL) ? DONE :
                  (state_q == DONE && OutReady)          ? IDLE : state_q;
    end

    always_comb begin
        InReady  = state_q == IDLE;
        OutValid = state_q == DONE;
        Busy     = state_q != IDLE;
    end

    assign accept  = InReady & InValid;
    assign DataOut = dout_q;

    // Column 0 lives in the top word, so the word index is 3-cnt, i.e. ~cnt.
    always_comb begin
        col = st_q[{~cnt_q, 5'd0} +: 32];
    end

    mix_column u_mix (
        .col_i(col),
        .col_o(mixed)
    );

`ifdef MIXCOL_BYPASS_EN
    logic last_q, last_d;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) last_q <= 1'b0;
        else     last_q <= last_d;
    end

    assign last_d = accept ? Last : last_q;
    assign res    = last_q ? col : mixed;
`else
    assign res = mixed;
`endif

    always_comb begin
        st_d   = accept ? DataIn : st_q;
        cnt_d  = accept ? 2'd0 : (state_q == CALC && cnt_q != LAST_COL) ? cnt_q + 2'd1 : cnt_q;
        dout_d = dout_q;
        if (state_q == CALC) dout_d[{~cnt_q, 5'd0} +: 32] = res;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q  <= 2'd0;
            st_q   <= '0;
            dout_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            st_q   <= st_d;
            dout_q <= dout_d;
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: directed known-answer bench for mix_columns_seq (define MIXCOL_BYPASS_EN for bypass cases).
module tb_mix_columns_seq;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         InValid = 1'b0;
    logic         InReady;
    logic [127:0] DataIn = '0;
    logic         OutValid;
    logic         OutReady = 1'b0;
    logic [127:0] DataOut;
    logic         Busy;
`ifdef MIXCOL_BYPASS_EN
    logic         Last = 1'b0;
`endif

    int n_chk = 0;
    int n_fail = 0;

    localparam logic [127:0] KA_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] KA_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] FI_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] FI_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

    mix_columns_seq dut (
        .Clk(Clk),
        .Rst(Rst),
        .InValid(InValid),
        .InReady(InReady),
        .DataIn(DataIn),
        .OutValid(OutValid),
        .OutReady(OutReady),
        .DataOut(DataOut),
        .Busy(Busy)
`ifdef MIXCOL_BYPASS_EN
        ,
        .Last(Last)
`endif
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] d);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = d[127 - 32*c -: 32];
            r[127 - 32*c -: 32] = {
                gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9),
                gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13),
                gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11),
                gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14)};
        end
        return r;
    endfunction

    // Accept at E0, scramble DataIn afterwards, then step to E4 checking latency.
    task automatic run_to_done(input string tag, input logic [127:0] din, input logic [127:0] exp);
        DataIn  = din;
        InValid = 1'b1;
        tick;
        chk({tag, "_busy_e0"}, 128'(Busy), 128'(1));
        chk({tag, "_inready_e0"}, 128'(InReady), 128'(0));
        InValid = 1'b0;
        DataIn  = ~din;
        repeat (3) tick;
        chk({tag, "_ovalid_e3"}, 128'(OutValid), 128'(0));
        tick;
        chk({tag, "_ovalid_e4"}, 128'(OutValid), 128'(1));
        chk({tag, "_dout_e4"}, DataOut, exp);
    endtask

    task automatic drain(input string tag);
        OutReady = 1'b1;
        tick;
        OutReady = 1'b0;
        chk({tag, "_inready_e5"}, 128'(InReady), 128'(1));
        chk({tag, "_ovalid_e5"}, 128'(OutValid), 128'(0));
    endtask

    initial begin
        logic [127:0] held;
        #2;
        chk("rst_inready", 128'(InReady), 128'(1));
        chk("rst_ovalid", 128'(OutValid), 128'(0));
        chk("rst_busy", 128'(Busy), 128'(0));
        chk("rst_dout", DataOut, 128'h0);
        tick;
        Rst = 1'b0;
        tick;

        run_to_done("ka", KA_IN, KA_OUT);
        drain("ka");

        run_to_done("fips", FI_IN, FI_OUT);
        chk("fips_inverse", inv_mix(DataOut), FI_IN);
        drain("fips");

        // Backpressure: stall in DONE with a competing InValid present.
        run_to_done("bp", FI_IN, FI_OUT);
        held    = DataOut;
        DataIn  = KA_IN;
        InValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("bp_dout_hold", DataOut, held);
            chk("bp_inready_low", 128'(InReady), 128'(0));
            chk("bp_busy_high", 128'(Busy), 128'(1));
            chk("bp_ovalid_high", 128'(OutValid), 128'(1));
        end
        InValid = 1'b0;
        drain("bp");

        // Back-to-back with InValid held: accepts at E0 and E6.
        DataIn   = KA_IN;
        InValid  = 1'b1;
        OutReady = 1'b1;
        tick;
        chk("b2b_busy_e0", 128'(Busy), 128'(1));
        DataIn = FI_IN;
        repeat (4) tick;
        chk("b2b_ovalid_e4", 128'(OutValid), 128'(1));
        chk("b2b_dout_first", DataOut, KA_OUT);
        tick;
        chk("b2b_inready_e5", 128'(InReady), 128'(1));
        tick;
        chk("b2b_busy_e6", 128'(Busy), 128'(1));
        InValid = 1'b0;
        repeat (3) tick;
        chk("b2b_ovalid_e9", 128'(OutValid), 128'(0));
        tick;
        chk("b2b_ovalid_e10", 128'(OutValid), 128'(1));
        chk("b2b_dout_second", DataOut, FI_OUT);
        tick;
        chk("b2b_idle_e11", 128'(InReady), 128'(1));
        OutReady = 1'b0;

        // Reset asserted just after E2 takes effect without a clock edge.
        DataIn  = FI_IN;
        InValid = 1'b1;
        tick;
        InValid = 1'b0;
        repeat (2) tick;
        Rst = 1'b1;
        #1;
        chk("rst_mid_ovalid", 128'(OutValid), 128'(0));
        chk("rst_mid_dout", DataOut, 128'h0);
        chk("rst_mid_busy", 128'(Busy), 128'(0));
        tick;
        Rst = 1'b0;
        tick;
        chk("rst_mid_inready", 128'(InReady), 128'(1));
        run_to_done("post_rst", KA_IN, KA_OUT);
        drain("post_rst");

`ifdef MIXCOL_BYPASS_EN
        Last = 1'b1;
        run_to_done("bypass", KA_IN, KA_IN);
        drain("bypass");
        Last = 1'b0;
        run_to_done("nobypass", KA_IN, KA_OUT);
        drain("nobypass");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
# mix_columns_seq

Sequential forward AES MixColumns unit for the encryption datapath. It is the counterpart of the combinational inverse MixColumns used on the decrypt side. It accepts a 128-bit state over a valid/ready handshake, processes one 32-bit column per clock through a single shared column multiplier, and presents the result on a held valid/ready output. It sits between ShiftRows and AddRoundKey in the iterative cipher round.

## Interface
Parameters: none; widths are fixed by AES.

Ports:
- Clk  in  1  single clock; all state changes on the rising edge
- Rst  in  1  reset, asynchronous, active-high
- InValid  in  1  DataIn valid
- InReady  out  1  block can accept; high only in IDLE
- DataIn  in  128  state; column 0 = [127:96], column 3 = [31:0]; byte s0 of each column is the MSB
- OutValid  out  1  DataOut valid
- OutReady  in  1  downstream accepts
- DataOut  out  128  MixColumns result, same column/byte order as DataIn
- Busy  out  1  high whenever state != IDLE
- Last  in  1  present only with MIXCOL_BYPASS_EN; sampled with DataIn

## Operation
- FSM states:
  - IDLE: InReady=1. When InValid is high, DataIn is captured into the internal state register. The column counter is cleared. Go to CALC.
  - CALC: each cycle, column[cnt] (cnt=0 first) passes through mix_column. The result is written into the DataOut register slice for cnt. cnt increments. After cnt=3 is written, go to DONE.
  - DONE: OutValid=1, and DataOut holds stable. When OutReady is high, go to IDLE.
- Column math over GF(2^8), with xt(b) = {b[6:0],0} ^ (8'h1b if b[7]):
  - o0 = 2s0^3s1^s2^s3
  - o1 = s0^2s1^3s2^s3
  - o2 = s0^s1^2s2^3s3
  - o3 = 3s0^s1^s2^2s3
  - 2b=xt(b); 3b=xt(b)^b.
- cnt is 2 bits and never wraps past 3 inside CALC. It is reset to 0 on each accept.
- Outside IDLE:
  - InValid is ignored.
  - DataIn changes after capture have no effect.
- OutReady is ignored outside DONE.
- Reset values: state IDLE, cnt 0, internal state register 0, DataOut 128'h0, OutValid 0, Busy 0, InReady 1.
- Reset asserted mid-CALC or in DONE: the operation aborts with no output handshake, and all registers return to their reset values asynchronously.

## Timing
- Input handshake (InValid & InReady) happens at edge E0.
- Columns 0..3 are written at edges E1..E4.
- OutValid is high from E4 until the edge at which OutValid & OutReady completes, at the earliest E5.
- Latency: 4 cycles from accept to OutValid.
- InReady returns high the cycle after the output handshake. The earliest next accept is E6, so minimum issue interval is 6 cycles.
- If OutReady is held low, the block stalls in DONE indefinitely with DataOut unchanged.
- InReady, OutValid and Busy are decoded from state registers only. There is no combinational path from any input to any output.

## Configuration
- MIXCOL_BYPASS_EN defined:
  - Adds the Last port. Last is captured at accept.
  - If Last=1, each column is written unchanged (final AES round skips MixColumns).
  - Latency and handshake are identical to the normal path.
- MIXCOL_BYPASS_EN undefined:
  - No Last port, no bypass logic.
  - Every block is mixed.

## Structure
- Shared package aes_pkg holds:
  - typedef enum logic [1:0] {IDLE, CALC, DONE} mixcol_state_t
  - localparam NUM_COLS = 4
  - function xt (byte xtime)
- Sub-module mix_column:
  - Combinational 32-bit single-column forward multiplier.
  - Instantiated once and muxed by cnt.

## Test plan
- Known answer: DataIn=db135345_f20a225c_01010101_c6c6c6c6 -> DataOut=8e4da1bc_9fdc589d_01010101_c6c6c6c6, OutValid at E4.
- FIPS-197 round-1 columns: DataIn=d4bf5d30_e0b452ae_b84111f1_1e2798e5 -> DataOut=046681e5_e0cb199a_48f8d37a_2806264c. The bench also checks that the inverse MixColumns block returns the original DataIn.
- Backpressure: hold OutReady=0 for 10 cycles after OutValid. Required: DataOut constant, InReady=0 and Busy=1 throughout, and a new InValid is not accepted. OutReady=1 -> IDLE on the next edge.
- Back-to-back: InValid held high with two different blocks and OutReady=1 -> accepts at E0 and E6, with both results correct and in order.
- Reset mid-op: assert Rst at E2 -> OutValid=0 and DataOut=0 immediately. After release the block is in IDLE with InReady=1, and the next block computes correctly.
- With MIXCOL_BYPASS_EN: Last=1 and DataIn=db135345_f20a225c_01010101_c6c6c6c6 -> DataOut equals DataIn at E4. Last=0 reproduces the first known-answer result.
